// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM state encoding and default datapath width    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// +--------------------------------------------------------------------+
// | alu_mul_seq : shift-add multiply engine, one iteration per i_step   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_mul_seq #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_step_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] w_acc_next;

  // The product is taken from the accumulator value this step produces,
  // so the owner can write its result on the same edge as the last add.
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_product   = w_acc_next;
  assign o_step_done = i_step && (r_count == CW'(MUL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_unit.sv
// +--------------------------------------------------------------------+
// | alu_unit : single-cycle ALU with optional multi-cycle shift-add MUL |
// | Build option: define ALU_MUL_EN to build the sequential multiplier. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             out_en,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_done;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;

  assign result  = r_result;
  assign carry   = r_carry;
  assign zero    = r_zero;
  assign done    = r_done;
  assign bus_out = out_en ? r_result : '0;

  // Opcode 111 falls to the default arm: pass-through when MUL is not built.
  always_comb begin
    w_alu_res   = a_in;
    w_alu_carry = 1'b0;
    case (op)
      OP_ADD:  {w_alu_carry, w_alu_res} = {1'b0, a_in} + {1'b0, b_in};
      OP_SUB: begin
        w_alu_res   = a_in - b_in;
        w_alu_carry = (a_in >= b_in);
      end
      OP_AND:  w_alu_res = a_in & b_in;
      OP_OR:   w_alu_res = a_in | b_in;
      OP_XOR:  w_alu_res = a_in ^ b_in;
      OP_SHL: begin
        w_alu_res   = {a_in[WIDTH-2:0], 1'b0};
        w_alu_carry = a_in[WIDTH-1];
      end
      OP_SHR: begin
        w_alu_res   = {1'b0, a_in[WIDTH-1:1]};
        w_alu_carry = a_in[0];
      end
      default: begin
        w_alu_res   = a_in;
        w_alu_carry = 1'b0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_e         r_state;
  logic               r_busy;
  logic               w_load;
  logic               w_step;
  logic               w_step_done;
  logic [2*WIDTH-1:0] w_product;

  assign busy   = r_busy;
  assign w_load = (r_state == ST_IDLE) && start && (op == OP_MUL);
  assign w_step = (r_state == ST_MUL);

  alu_mul_seq #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_seq (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_a         (a_in),
    .i_b         (b_in),
    .o_step_done (w_step_done),
    .o_product   (w_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && (op == OP_MUL)) begin
            r_busy  <= 1'b1;
            r_state <= ST_MUL;
          end else if (start) begin
            r_result <= w_alu_res;
            r_carry  <= w_alu_carry;
            r_zero   <= (w_alu_res == '0);
            r_done   <= 1'b1;
          end
        end
        ST_MUL: begin
          if (w_step_done) begin
            r_result <= w_product[WIDTH-1:0];
            r_carry  <= |w_product[2*WIDTH-1:WIDTH];
            r_zero   <= (w_product[WIDTH-1:0] == '0);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  logic w_unused_mul_cycles;

  assign busy                = 1'b0;
  assign w_unused_mul_cycles = ^MUL_CYCLES;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= start;
      if (start) begin
        r_result <= w_alu_res;
        r_carry  <= w_alu_carry;
        r_zero   <= (w_alu_res == '0);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- ALU stage directly downstream of the A/B operand registers; consumes the A register's ALU-side output and the B operand.
- Single-cycle ADD/SUB/logic/shift operations; shift-add multiply over multiple cycles.
- Holds a registered result and carry/zero flag registers for the controller.
- Drives the shared 8-bit bus only when out_en is high.

Parameters:
WIDTH, 8, datapath width in bits for operands, result and bus.
MUL_CYCLES, WIDTH, number of shift-add iterations for MUL.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active high
a_in  input  WIDTH  operand A, from the A register's ALU output
b_in  input  WIDTH  operand B, from the B register
op  input  3  opcode, sampled with start
start  input  1  begin an operation; sampled only in IDLE
out_en  input  1  drive result onto bus_out
bus_out  output  WIDTH  result when out_en=1, else all zeros
result  output  WIDTH  registered result, always visible
carry  output  1  carry flag register
zero  output  1  zero flag register
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse when an operation completes

Behaviour:
- Reset values: result=0, carry=0, zero=0, busy=0, done=0, state=IDLE, internal accumulator and counter = 0.
- Reset during MUL aborts the operation: no done pulse, all registers return to their reset values.
- Opcodes:
  - 000 ADD: {carry,result} = a + b.
  - 001 SUB: result = a - b; carry = (a >= b), i.e. not-borrow.
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SHL: result = a << 1; carry = a[WIDTH-1].
  - 110 SHR: result = a >> 1 (logical); carry = a[0].
  - 111 MUL: result = low WIDTH bits of a*b; carry = 1 if the high WIDTH bits are nonzero.
- zero = (result == 0). It is updated at the same edge as result, on every completion.
- States: IDLE, MUL.
- IDLE, start=1, op != 111:
  - result and flags are written at that edge; done=1 for the following cycle; state stays IDLE.
  - Latency is 1 cycle, and start may be asserted back-to-back.
- IDLE, start=1, op = 111:
  - At that edge: latch multiplicand (zero-extended to 2*WIDTH), multiplier, acc=0, count=0; busy<=1; state -> MUL.
- MUL, each cycle:
  - If multiplier[0], acc += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, count++.
  - On the iteration where count == MUL_CYCLES-1: write result and flags from the final acc; busy<=0; done<=1; state -> IDLE.
  - done is therefore high during the cycle MUL_CYCLES+1 after the start edge.
- start while busy is ignored; a_in and b_in may change freely during MUL.
- result and flags hold their values between operations.
- bus_out is combinational: out_en ? result : 0. The internal bus is OR-muxed, not tri-stated.
- Simultaneous start and out_en: bus_out shows the old result until the completion edge.

Optional Feature:
- ALU_MUL_EN defined: MUL behaves as specified above.
- ALU_MUL_EN undefined:
  - Opcode 111 is a 1-cycle pass-through: result = a, carry = 0.
  - The MUL state, accumulator and counter are not built; busy is tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL (3 bits);
  - state encoding ST_IDLE and ST_MUL;
  - the default WIDTH constant shared with the register blocks.
- One sub-module, alu_mul_seq, is natural:
  - contains the shift-add engine (acc, shift registers, counter);
  - interface: load, operands, step_done, product;
  - instantiated only under ALU_MUL_EN.

Test Plan:
- Reset, then ADD a=0xF0 b=0x20 -> next cycle result=0x10, carry=1, zero=0, done pulse 1 cycle; bus_out=0x10 only while out_en=1, else 0x00.
- SUB a=0x05 b=0x05 -> result=0x00, carry=1, zero=1; SUB a=0x03 b=0x05 -> result=0xFE, carry=0, zero=0.
- SHL a=0x81 -> result=0x02, carry=1; SHR a=0x81 -> result=0x40, carry=1; XOR a=0xAA b=0xAA -> result=0x00, zero=1, carry=0.
- MUL a=0x0C b=0x0B -> busy for 8 cycles, done in cycle 9 after start, result=0x84, carry=0; MUL 0x10*0x10 -> result=0x00, carry=1, zero=1.
- Start MUL, assert rst in cycle 4 -> next cycle busy=0, result=0, flags=0, no done pulse; a new ADD 0x01+0x01 then gives result=0x02.
- During MUL, pulse start with op=ADD and change a_in/b_in -> ignored; the MUL result is unaffected. Without ALU_MUL_EN: op=111, a=0x5A -> result=0x5A after 1 cycle, busy stays 0.
